// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, func3 encodings and wait-state limit for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int WAIT_CYC_MAX = 15;
endpackage

// File: rtl/dmem_lane_ext.sv
// dmem_lane_ext: load lane select/extend, store byte-enables and lane replication; misalign flag under DMEM_MISALIGN_TRAP_EN
module dmem_lane_ext
  import dmem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  output logic [31:0] ld_data,
  output logic [3:0]  be,
  output logic [31:0] wr_word,
  output logic        mis
);
  logic is_b, is_h, uns;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    is_b = func3 == F3_B || func3 == F3_BU;
    is_h = func3 == F3_H || func3 == F3_HU;
    uns = func3 == F3_BU || func3 == F3_HU;
    b = rd_word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = is_b ? {{24{b[7] & ~uns}}, b} : is_h ? {{16{h[15] & ~uns}}, h} : rd_word;
    be = is_b ? 4'b0001 << addr_lo : is_h ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wr_word = is_b ? {4{wr_data[7:0]}} : is_h ? {2{wr_data[15:0]}} : wr_data;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = is_h ? addr_lo[0] : !is_b && addr_lo != 2'b00;
`else
    mis = 1'b0;
`endif
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: little-endian data memory target with WAIT_CYC wait states and valid/ready handshake; DMEM_MISALIGN_TRAP_EN adds misalign port
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  wr,
  input  logic                  reade,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  busy
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic                  misalign
`endif
);
  localparam logic [3:0] WC = 4'(WAIT_CYC > WAIT_CYC_MAX ? WAIT_CYC_MAX : WAIT_CYC);
  dmem_state_e state, nxt;
  logic [3:0] cnt;
  logic [DM_ADDRESS-1:0] addr_q, a_addr;
  logic [DATA_W-1:0] wd_q, a_wd, rd_word, ld_data, wr_word;
  logic [2:0] f3_q, a_f3;
  logic [3:0] be;
  logic wr_q, a_wr, acc, go, mis;
  logic [DATA_W-1:0] mem [2**(DM_ADDRESS-2)];
  always_comb begin
    acc = req_valid && state == IDLE && (wr || reade);
    nxt = state == IDLE ? (acc ? (WC == 4'd0 ? RESP : WAIT) : IDLE) : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
    go = nxt == RESP;
    a_addr = state == IDLE ? addr : addr_q;
    a_wd = state == IDLE ? wr_data : wd_q;
    a_f3 = state == IDLE ? func3 : f3_q;
    a_wr = state == IDLE ? wr : wr_q;
    rd_word = mem[a_addr[DM_ADDRESS-1:2]];
    req_ready = state == IDLE;
    busy = state != IDLE;
  end
  dmem_lane_ext u_lane (
    .func3(a_f3),
    .addr_lo(a_addr[1:0]),
    .rd_word(rd_word),
    .wr_data(a_wd),
    .ld_data(ld_data),
    .be(be),
    .wr_word(wr_word),
    .mis(mis)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      addr_q <= '0;
      wd_q <= '0;
      f3_q <= 3'd0;
      wr_q <= 1'b0;
      rsp_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= nxt;
      cnt <= acc ? WC : state == WAIT ? cnt - 4'd1 : cnt;
      if (acc) begin
        addr_q <= addr;
        wd_q <= wr_data;
        f3_q <= func3;
        wr_q <= wr;
      end
      rsp_valid <= go;
      if (go) rd_data <= a_wr || mis ? '0 : ld_data;
    end
`ifdef DMEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) misalign <= 1'b0;
    else misalign <= go && mis;
`endif
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (go && a_wr && !mis && be[i]) mem[a_addr[DM_ADDRESS-1:2]][8*i +: 8] <= wr_word[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven scoreboard bench for dmem_responder (WAIT_CYC=2 and WAIT_CYC=0 instances)
module tb_dmem_responder;
  localparam int WC = 2;
  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          at;
  } exp_t;
  typedef struct {
    logic        w;
    logic        r;
    logic [8:0]  a;
    logic [31:0] d;
    logic [2:0]  f;
    logic [31:0] ex;
    logic        em;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0;
  logic rv = 1'b0, wr = 1'b0, rd = 1'b0, rdy, rsp, busy;
  logic [8:0] addr = '0;
  logic [31:0] wd = '0, rdat;
  logic [2:0] f3 = '0;
  logic rv1 = 1'b0, wr1 = 1'b0, rd1 = 1'b0, rdy1, rsp1, busy1;
  logic [8:0] addr1 = '0;
  logic [31:0] wd1 = '0, rdat1;
  logic [2:0] f31 = '0;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis, mis1;
`endif
  int cyc = 0, total = 0, bad = 0;
  exp_t q[$];
  exp_t e;
  vec_t tv[20];
  int acc1[$], rsp1q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dmem_responder #(.WAIT_CYC(WC)) u0 (
    .clk(clk), .reset(reset), .req_valid(rv), .req_ready(rdy), .wr(wr), .reade(rd),
    .addr(addr), .wr_data(wd), .func3(f3), .rsp_valid(rsp), .rd_data(rdat), .busy(busy)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .misalign(mis)
`endif
  );
  dmem_responder #(.WAIT_CYC(0)) u1 (
    .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rdy1), .wr(wr1), .reade(rd1),
    .addr(addr1), .wr_data(wd1), .func3(f31), .rsp_valid(rsp1), .rd_data(rdat1), .busy(busy1)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .misalign(mis1)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, ex);
    end
  endtask
  always @(negedge clk)
    if (reset) begin
      chk("busy_vs_ready", {31'd0, busy}, {31'd0, !rdy});
      if (rsp) begin
        if (q.size() == 0) chk("unexpected_rsp", {31'd0, rsp}, 32'd0);
        else begin
          e = q.pop_front();
          chk("rd_data", rdat, e.rd);
          chk("latency", cyc, e.at);
`ifdef DMEM_MISALIGN_TRAP_EN
          chk("misalign", {31'd0, mis}, {31'd0, e.mis});
`endif
        end
      end
    end
  task automatic req(input vec_t v);
    exp_t x;
    @(negedge clk);
    rv = 1'b1; wr = v.w; rd = v.r; addr = v.a; wd = v.d; f3 = v.f;
    for (int i = 0; i < 20 && !rdy; i++) @(negedge clk);
    x.rd = v.ex; x.mis = v.em; x.at = cyc + WC + 1;
    q.push_back(x);
    @(negedge clk);
    rv = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("rsp_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
  initial begin
    tv[0]  = '{1'b1, 1'b0, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 9'h010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 9'h020, 32'h11223344, 3'b010, 32'h0, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 9'h021, 32'hABCDEF80, 3'b000, 32'h0, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 9'h021, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 9'h021, 32'h0,        3'b100, 32'h00000080, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 9'h020, 32'h0,        3'b010, 32'h11228044, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 9'h023, 32'h0,        3'b000, 32'h00000011, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 9'h020, 32'h0,        3'b001, 32'hFFFF8044, 1'b0};
    tv[9]  = '{1'b1, 1'b0, 9'h030, 32'hA5A5A5A5, 3'b010, 32'h0, 1'b0};
    tv[10] = '{1'b1, 1'b0, 9'h032, 32'h12348001, 3'b001, 32'h0, 1'b0};
    tv[11] = '{1'b0, 1'b1, 9'h032, 32'h0,        3'b001, 32'hFFFF8001, 1'b0};
    tv[12] = '{1'b0, 1'b1, 9'h032, 32'h0,        3'b101, 32'h00008001, 1'b0};
    tv[13] = '{1'b0, 1'b1, 9'h030, 32'h0,        3'b010, 32'h8001A5A5, 1'b0};
    tv[14] = '{1'b1, 1'b1, 9'h040, 32'h0BADF00D, 3'b010, 32'h0, 1'b0};
    tv[15] = '{1'b0, 1'b1, 9'h040, 32'h0,        3'b010, 32'h0BADF00D, 1'b0};
    tv[16] = '{1'b0, 1'b1, 9'h010, 32'h0,        3'b011, 32'hDEADBEEF, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
    tv[17] = '{1'b0, 1'b1, 9'h013, 32'h0,        3'b010, 32'h0, 1'b1};
    tv[18] = '{1'b0, 1'b1, 9'h033, 32'h0,        3'b001, 32'h0, 1'b1};
`else
    tv[17] = '{1'b0, 1'b1, 9'h013, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
    tv[18] = '{1'b0, 1'b1, 9'h033, 32'h0,        3'b001, 32'hFFFF8001, 1'b0};
`endif
    tv[19] = '{1'b0, 1'b1, 9'h022, 32'h0,        3'b100, 32'h00000022, 1'b0};
    @(negedge clk);
    chk("rst_ready", {31'd0, rdy}, 32'd1);
    chk("rst_rsp", {31'd0, rsp}, 32'd0);
    chk("rst_rd_data", rdat, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst1_ready", {31'd0, rdy1}, 32'd1);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) req(tv[k]);
    chk("rd_hold", rdat, 32'h00000022);
    @(negedge clk);
    rv = 1'b1; wr = 1'b0; rd = 1'b0; addr = 9'h010; f3 = 3'b010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ignored_busy", {31'd0, busy}, 32'd0);
    end
    rv = 1'b0;
    @(negedge clk);
    rv = 1'b1; wr = 1'b1; rd = 1'b0; addr = 9'h010; wd = 32'h55555555; f3 = 3'b010;
    @(negedge clk);
    rv = 1'b0;
    chk("abort_accepted", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_ready", {31'd0, rdy}, 32'd1);
    chk("abort_rsp", {31'd0, rsp}, 32'd0);
    chk("abort_rd_data", rdat, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("abort_misalign", {31'd0, mis}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    req('{1'b0, 1'b1, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0});
    @(negedge clk);
    rv1 = 1'b1; wr1 = 1'b1; rd1 = 1'b0; addr1 = 9'h100; wd1 = 32'h12345678; f31 = 3'b010;
    for (int i = 0; i < 6; i++) begin
      if (rdy1) acc1.push_back(cyc);
      if (rsp1) begin
        rsp1q.push_back(cyc);
        chk("b2b_store_rd", rdat1, 32'd0);
      end
      @(negedge clk);
    end
    wr1 = 1'b0; rd1 = 1'b1;
    @(negedge clk);
    rv1 = 1'b0;
    chk("b2b_raw_valid", {31'd0, rsp1}, 32'd1);
    chk("b2b_raw_data", rdat1, 32'h12345678);
    chk("b2b_accepts", acc1.size(), 32'd3);
    chk("b2b_rsps", rsp1q.size(), 32'd3);
    if (acc1.size() == 3 && rsp1q.size() == 3)
      for (int k = 0; k < 3; k++) begin
        chk("b2b_lat", rsp1q[k] - acc1[k], 32'd1);
        if (k > 0) chk("b2b_gap", acc1[k] - acc1[k-1], 32'd2);
      end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
